dvr_fifo16: RTL and testbench

DVR_FIFO16 -- requirements
Module: dvr_fifo16

---
 rtl/dvr_fifo16.sv | 64 ++++++
 tb/tb_dvr_fifo16.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dvr_fifo16.sv
// 16-bit first-word-fall-through FIFO with a registered occupancy count.
// Define DVR_FIFO16_LEVEL_EN to expose the count on level_out.
module dvr_fifo16 #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] data16_in,
  input  logic        valid16_in,
  output logic        ready16_out,
  output logic [15:0] data16_out,
  output logic        valid16_out,
  input  logic        ready16_in
`ifdef DVR_FIFO16_LEVEL_EN
  ,output logic [ADDR_W:0] level_out
`endif
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              wr_en;
  logic              rd_en;

  // Handshakes depend only on the registered count, so there is no input-to-output path.
  always_comb begin
    ready16_out = (count != FULL_COUNT);
    valid16_out = (count != '0);
    wr_en       = valid16_in && ready16_out;
    rd_en       = valid16_out && ready16_in;
    data16_out  = mem[rd_ptr];
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= data16_in;
  end

`ifdef DVR_FIFO16_LEVEL_EN
  assign level_out = count;
`endif

endmodule

// File: tb/tb_dvr_fifo16.sv
// Randomized self-checking bench for dvr_fifo16 against a queue-based reference model.
module tb_dvr_fifo16;
  localparam int unsigned DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [15:0] data16_in;
  logic        valid16_in;
  logic        ready16_out;
  logic [15:0] data16_out;
  logic        valid16_out;
  logic        ready16_in;
`ifdef DVR_FIFO16_LEVEL_EN
  logic [3:0]  level_out;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] q[$];

  dvr_fifo16 #(.DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .data16_in   (data16_in),
    .valid16_in  (valid16_in),
    .ready16_out (ready16_out),
    .data16_out  (data16_out),
    .valid16_out (valid16_out),
    .ready16_in  (ready16_in)
`ifdef DVR_FIFO16_LEVEL_EN
    ,.level_out  (level_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Drives one cycle of stimulus and advances the model by the handshake rules.
  task automatic cycle(input logic vin, input logic [15:0] din, input logic rin);
    bit w, r;
    valid16_in = vin;
    data16_in  = din;
    ready16_in = rin;
    @(posedge clk_in);
    w = vin && (q.size() < DEPTH) && !reset_in;
    r = rin && (q.size() != 0) && !reset_in;
    if (r) void'(q.pop_front());
    if (w) q.push_back(din);
    #1;
  endtask

  task automatic test_reset;
    reset_in = 1'b1; valid16_in = 1'b1; ready16_in = 1'b1; data16_in = 16'h5555;
    repeat (2) @(posedge clk_in);
    #1;
    total++; if (valid16_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid16_out); end
    total++; if (ready16_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready16_out); end
`ifdef DVR_FIFO16_LEVEL_EN
    total++; if (level_out !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_out); end
`endif
    valid16_in = 1'b0; ready16_in = 1'b0;
    reset_in = 1'b0;
    q.delete();
  endtask

  task automatic test_basic;
    cycle(1'b1, 16'h1234, 1'b0);
    valid16_in = 1'b0;
    total++; if (valid16_out !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", valid16_out); end
    total++; if (data16_out !== 16'h1234) begin bad++; $display("FAIL basic_data got=%h exp=1234", data16_out); end
    total++; if (ready16_out !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", ready16_out); end
    cycle(1'b0, 16'h0, 1'b1);
    total++; if (valid16_out !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", valid16_out); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0);
    total++; if (ready16_out !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", ready16_out); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h0009, 1'b0);
      total++; if (ready16_out !== 1'b0 || data16_out !== 16'h0001) begin
        bad++; $display("FAIL fill_hold ready=%b data=%h exp ready=0 data=0001", ready16_out, data16_out);
      end
    end
`ifdef DVR_FIFO16_LEVEL_EN
    total++; if (level_out !== 4'd8) begin bad++; $display("FAIL fill_level got=%0d exp=8", level_out); end
`endif
    // Read while full frees a slot; the held word 0x0009 lands on the following edge.
    cycle(1'b1, 16'h0009, 1'b1);
    total++; if (ready16_out !== 1'b1 || data16_out !== 16'h0002) begin
      bad++; $display("FAIL full_read ready=%b data=%h exp ready=1 data=0002", ready16_out, data16_out);
    end
    cycle(1'b1, 16'h0009, 1'b0);
    total++; if (ready16_out !== 1'b0) begin bad++; $display("FAIL full_refill got=%b exp=0", ready16_out); end
    for (int i = 2; i <= 9; i++) begin
      total++; if (valid16_out !== 1'b1 || data16_out !== 16'(i)) begin
        bad++; $display("FAIL drain valid=%b data=%h exp valid=1 data=%h", valid16_out, data16_out, 16'(i));
      end
      cycle(1'b0, 16'h0, 1'b1);
    end
    total++; if (valid16_out !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", valid16_out); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'hA000 + 16'(i), 1'b1);
      total++; if (valid16_out !== 1'b1 || data16_out !== 16'hA000 + 16'(i) || q.size() > 1) begin
        bad++; $display("FAIL wrap valid=%b data=%h exp valid=1 data=%h", valid16_out, data16_out, 16'hA000 + 16'(i));
      end
    end
    cycle(1'b0, 16'h0, 1'b1);
    total++; if (valid16_out !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", valid16_out); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 99) < 45));
      total++;
      if (valid16_out !== (q.size() != 0) || ready16_out !== (q.size() != DEPTH) ||
          (q.size() != 0 && data16_out !== q[0])) begin
        bad++;
        $display("FAIL random cyc=%0d valid=%b ready=%b data=%h exp size=%0d head=%h",
                 i, valid16_out, ready16_out, data16_out, q.size(), (q.size() != 0) ? q[0] : 16'h0);
      end
`ifdef DVR_FIFO16_LEVEL_EN
      total++; if (level_out !== 4'(q.size())) begin bad++; $display("FAIL random_level got=%0d exp=%0d", level_out, q.size()); end
`endif
    end
    while (q.size() != 0) cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0);
    valid16_in = 1'b0;
    #2 reset_in = 1'b1;
    #1;
    total++; if (valid16_out !== 1'b0 || ready16_out !== 1'b1) begin
      bad++; $display("FAIL async_reset valid=%b ready=%b exp valid=0 ready=1", valid16_out, ready16_out);
    end
    q.delete();
    cycle(1'b1, 16'hDEAD, 1'b1);
    total++; if (valid16_out !== 1'b0) begin bad++; $display("FAIL reset_ignores_write got=%b exp=0", valid16_out); end
    reset_in = 1'b0;
    cycle(1'b1, 16'hBEEF, 1'b0);
    total++; if (valid16_out !== 1'b1 || data16_out !== 16'hBEEF) begin
      bad++; $display("FAIL after_reset valid=%b data=%h exp valid=1 data=beef", valid16_out, data16_out);
    end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_chain;
    logic [7:0] bytes [4];
    logic [15:0] exp_w [2];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 2; i++) begin
      exp_w[i] = {bytes[2*i], bytes[2*i+1]};
      cycle(1'b1, exp_w[i], 1'b1);
      total++; if (valid16_out !== 1'b1 || data16_out !== exp_w[i]) begin
        bad++; $display("FAIL chain valid=%b data=%h exp valid=1 data=%h", valid16_out, data16_out, exp_w[i]);
      end
    end
    cycle(1'b0, 16'h0, 1'b1);
    total++; if (valid16_out !== 1'b0) begin bad++; $display("FAIL chain_empty got=%b exp=0", valid16_out); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_wrap;
    test_random;
    test_reset_mid;
    test_chain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
